// File: rtl/mac_chain_seq.sv
// Time-multiplexed STAGES-deep multiply-accumulate chain: x(k+1) = x(k)*B[k] + C[k],
// evaluated one stage per cycle on a single shared MAC, with valid/ready operand and result ports.
module mac_chain_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int STAGES     = 10,
    parameter int IDX_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [DATA_WIDTH-1:0] cfg_b,
    input  logic [DATA_WIDTH-1:0] cfg_c,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGES - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] b_q [STAGES];
    logic [DATA_WIDTH-1:0] b_d [STAGES];
    logic [DATA_WIDTH-1:0] c_q [STAGES];
    logic [DATA_WIDTH-1:0] c_d [STAGES];
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0] mac_res;

    // Product and sum are both sized to DATA_WIDTH, so each stage truncates and wraps.
    assign mac_res = acc_q * b_q[idx_q] + c_q[idx_q];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        b_d     = b_q;
        c_d     = c_q;

        unique case (state_q)
            IDLE: begin
                if (cfg_we && cfg_idx <= LAST_IDX) begin
                    b_d[cfg_idx] = cfg_b;
                    c_d[cfg_idx] = cfg_c;
                end
                if (in_valid) begin
                    acc_d   = in_a;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = mac_res;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == HOLD);
        out_data_d  = (state_d == HOLD) ? acc_d : '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
            // NOTE: the coefficient file is reset on purpose, restoring the identity chain.
            for (int k = 0; k < STAGES; k++) begin
                b_q[k] <= DATA_WIDTH'(1);
                c_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
            b_q         <= b_d;
            c_q         <= c_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mac_chain_seq.sv
// Directed bench for mac_chain_seq: expected results are queued at operand accept
// and popped when the DUT presents a result.
module tb_mac_chain_seq;

    localparam int DW     = 16;
    localparam int STAGES = 10;
    localparam int IDX_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [DW-1:0]     cfg_b, cfg_c;
    logic              in_valid, in_ready;
    logic [DW-1:0]     in_a;
    logic              out_valid, out_ready;
    logic [DW-1:0]     out_data;
    logic              busy;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] sb [$];

    mac_chain_seq #(.DATA_WIDTH(DW), .STAGES(STAGES), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_b    (cfg_b),
        .cfg_c    (cfg_c),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [IDX_W-1:0] i, input logic [DW-1:0] b, input logic [DW-1:0] c);
        cfg_we  = 1'b1;
        cfg_idx = i;
        cfg_b   = b;
        cfg_c   = c;
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] exp);
        int w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        check("accept_wait", 32'(w < 50), 1);
        in_valid = 1'b1;
        in_a     = a;
        sb.push_back(exp);
        tick();
        in_valid = 1'b0;
        in_a     = '0;
    endtask

    task automatic wait_result(input int lat_exp, input int stall);
        int            cyc = 0;
        logic [DW-1:0] exp;
        while (out_valid !== 1'b1 && cyc < 40) begin
            check("run_in_ready", in_ready, 0);
            check("run_busy", busy, 1);
            tick();
            cyc++;
        end
        check("latency", cyc, lat_exp);
        check("hold_busy", busy, 1);
        check("hold_in_ready", in_ready, 0);
        check("sb_nonempty", 32'(sb.size() > 0), 1);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        check("result", out_data, exp);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_a     = 16'hBEEF;
            tick();
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, exp);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
        check("post_out_data", out_data, 0);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_b     = '0;
        cfg_c     = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);

        // Identity chain, with the result held under backpressure for 5 cycles.
        start_op(16'h1234, 16'h1234);
        wait_result(STAGES, 5);

        // B = 2, C = 1 everywhere: 1 -> 2^11 - 1, and 0xFFFF is a fixed point.
        for (int k = 0; k < STAGES; k++) cfg_write(IDX_W'(k), 16'd2, 16'd1);
        start_op(16'h0001, 16'h07FF);
        wait_result(STAGES, 0);
        start_op(16'hFFFF, 16'hFFFF);
        wait_result(STAGES, 0);

        // B = 0x0100, C = 0: the value wraps to zero after two stages.
        for (int k = 0; k < STAGES; k++) cfg_write(IDX_W'(k), 16'h0100, 16'h0000);
        start_op(16'h0001, 16'h0000);
        wait_result(STAGES, 0);
        cfg_write(IDX_W'(9), 16'h0100, 16'hABCD);
        start_op(16'h0001, 16'hABCD);
        wait_result(STAGES, 0);

        // Reset during the 4th RUN cycle discards the operand and restores identity.
        in_valid = 1'b1;
        in_a     = 16'h4321;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        for (int i = 0; i < 15; i++) begin
            check("abort_no_output", out_valid, 0);
            tick();
        end
        start_op(16'h5555, 16'h5555);
        wait_result(STAGES, 0);

        // Writes during RUN and to an out-of-range index are both dropped.
        start_op(16'h0777, 16'h0777);
        cfg_we  = 1'b1;
        cfg_idx = IDX_W'(3);
        cfg_b   = 16'h0000;
        cfg_c   = 16'h00FF;
        tick();
        cfg_we  = 1'b0;
        wait_result(STAGES - 1, 0);
        cfg_write(IDX_W'(10), 16'h0000, 16'h1111);
        start_op(16'h0999, 16'h0999);
        wait_result(STAGES, 0);

        // A write in the accept cycle applies to the operand just accepted.
        cfg_we  = 1'b1;
        cfg_idx = IDX_W'(0);
        cfg_b   = 16'd3;
        cfg_c   = 16'd0;
        start_op(16'd2, 16'd6);
        cfg_we  = 1'b0;
        wait_result(STAGES, 0);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
